// File: rtl/da_pkg.sv
// Shared encodings and defaults for the DA source scheduler.
// Holds the FSM state / src_sel codes and parameter defaults.
package da_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEMOD = 2'd1,
        ST_TONE  = 2'd2
    } state_t;

    localparam logic [7:0]  FREQ_ADJ_DEF  = 8'd4;
    localparam logic [7:0]  IDLE_CODE_DEF = 8'd128;
    localparam logic [15:0] HOLD_MAX_DEF  = 16'd1023;

endpackage

// File: rtl/da_src_sched_if.sv
// Source/ROM/DA signal bundle of the DA source scheduler.
// master: sample source + ROM side; slave: the scheduler.
interface da_src_sched_if;

    logic [7:0] demod_data;
    logic       demod_valid;
    logic       tone_en;
    logic [7:0] rom_data;
    logic [7:0] rom_addr;
    logic [7:0] da_data;
    logic       da_clk;
    logic [1:0] src_sel;
    logic       underrun;

    modport master (
        output demod_data,
        output demod_valid,
        output tone_en,
        output rom_data,
        input  rom_addr,
        input  da_data,
        input  da_clk,
        input  src_sel,
        input  underrun
    );

    modport slave (
        input  demod_data,
        input  demod_valid,
        input  tone_en,
        input  rom_data,
        output rom_addr,
        output da_data,
        output da_clk,
        output src_sel,
        output underrun
    );

endinterface

// File: rtl/da_tone_addr_gen.sv
// Tone ROM address generator: divider 0..FREQ_ADJ, address steps on wrap.
// Ports: clk, rst_n, run (clears when low), rom_addr, wrap (period end).
module da_tone_addr_gen
    import da_pkg::*;
#(
    parameter logic [7:0] FREQ_ADJ = FREQ_ADJ_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [7:0] rom_addr,
    output logic       wrap
);

    logic [7:0] div_q;
    logic [7:0] div_d;
    logic [7:0] addr_q;
    logic [7:0] addr_d;
    logic       div_end;

    assign div_end = (div_q == FREQ_ADJ);

    always_comb begin
        div_d  = 8'd0;
        addr_d = 8'd0;
        if (run) begin
            if (div_end) begin
                div_d  = 8'd0;
                addr_d = addr_q + 8'd1;
            end else begin
                div_d  = div_q + 8'd1;
                addr_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= 8'd0;
            addr_q <= 8'd0;
        end else begin
            div_q  <= div_d;
            addr_q <= addr_d;
        end
    end

    assign rom_addr = addr_q;
    // Last cycle of a whole tone period.
    assign wrap = run && div_end && (addr_q == 8'hFF);

endmodule

// File: rtl/da_src_sched.sv
// DA source scheduler: picks idle code, demod samples or ROM tone.
// Ports: clk, rst_n, bus (slave: demod/tone/ROM in, DA/status out).
module da_src_sched
    import da_pkg::*;
#(
    parameter logic [7:0]  FREQ_ADJ  = FREQ_ADJ_DEF,
    parameter logic [7:0]  IDLE_CODE = IDLE_CODE_DEF,
    parameter logic [15:0] HOLD_MAX  = HOLD_MAX_DEF
) (
    input logic          clk,
    input logic          rst_n,
    da_src_sched_if.slave bus
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] hold_q;
    logic [15:0] hold_d;
    logic [7:0]  da_q;
    logic [7:0]  da_d;
    logic        underrun_q;
    logic        underrun_d;
    logic        tone_vld_q;
    logic        tone_run;
    logic        tone_wrap;
    logic [7:0]  rom_addr_w;

    assign tone_run = (state_q == ST_TONE);

    da_tone_addr_gen #(
        .FREQ_ADJ (FREQ_ADJ)
    ) u_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (tone_run),
        .rom_addr (rom_addr_w),
        .wrap     (tone_wrap)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = 16'd0;
        da_d       = da_q;
        underrun_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                da_d = IDLE_CODE;
                if (bus.tone_en) begin
                    state_d = ST_TONE;
                end else if (bus.demod_valid) begin
                    // The request sample itself goes out.
                    state_d = ST_DEMOD;
                    da_d    = bus.demod_data;
                end
            end
            ST_DEMOD: begin
                if (bus.demod_valid) begin
                    da_d = bus.demod_data;
                end
                if (bus.tone_en) begin
                    state_d = ST_TONE;
                end else if (bus.demod_valid) begin
                    hold_d = 16'd0;
                end else if (hold_q == HOLD_MAX - 16'd1) begin
                    state_d    = ST_IDLE;
                    underrun_d = 1'b1;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            ST_TONE: begin
                // rom_data is stale until one TONE cycle has passed.
                if (tone_vld_q) begin
                    da_d = bus.rom_data;
                end
                if (!bus.tone_en && tone_wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= 16'd0;
            da_q       <= IDLE_CODE;
            underrun_q <= 1'b0;
            tone_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            da_q       <= da_d;
            underrun_q <= underrun_d;
            tone_vld_q <= tone_run;
        end
    end

    assign bus.rom_addr = rom_addr_w;
    assign bus.da_data  = da_q;
    assign bus.src_sel  = state_q;
    assign bus.underrun = underrun_q;
    assign bus.da_clk   = ~clk;

endmodule

// File: tb/tb_da_src_sched.sv
// Directed bench for da_src_sched (default build plus FREQ_ADJ=0 build).
// Ports: none; drives two interface instances with a registered ROM.
module tb_da_src_sched;
    import da_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    da_src_sched_if bus ();
    da_src_sched_if fbus ();

    da_src_sched u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    da_src_sched #(
        .FREQ_ADJ (8'd0)
    ) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fbus.slave)
    );

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        bus.rom_data  <= rom_f(bus.rom_addr);
        fbus.rom_data <= rom_f(fbus.rom_addr);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.src_sel !== 2'd0 || bus.da_data !== 8'h80 ||
            bus.rom_addr !== 8'd0 || bus.underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset got sel=%0d da=%h addr=%h ur=%b exp 0 80 00 0",
                     bus.src_sel, bus.da_data, bus.rom_addr, bus.underrun);
        end
        checks++;
        if (bus.da_clk !== 1'b1) begin
            errors++;
            $display("FAIL da_clk_low got %b exp 1", bus.da_clk);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.da_clk !== 1'b0) begin
            errors++;
            $display("FAIL da_clk_high got %b exp 0", bus.da_clk);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.src_sel !== 2'd0 || bus.da_data !== 8'h80) begin
            errors++;
            $display("FAIL post_reset got sel=%0d da=%h exp 0 80",
                     bus.src_sel, bus.da_data);
        end
    endtask

    task automatic test_demod();
        logic [7:0] v [0:2];
        v[0] = 8'h10;
        v[1] = 8'h20;
        v[2] = 8'h30;
        bus.demod_valid = 1'b1;
        bus.demod_data  = v[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.da_data !== v[i] || bus.src_sel !== 2'd1) begin
                errors++;
                $display("FAIL demod_%0d got da=%h sel=%0d exp %h 1",
                         i, bus.da_data, bus.src_sel, v[i]);
            end
            if (i < 2) begin
                bus.demod_data = v[i+1];
            end
        end
        bus.demod_valid = 1'b0;
        bus.demod_data  = 8'hEE;
        tick();
        checks++;
        if (bus.da_data !== 8'h30) begin
            errors++;
            $display("FAIL demod_hold got %h exp 30", bus.da_data);
        end
    endtask

    task automatic test_no_underrun();
        bit seen = 1'b0;
        bus.demod_valid = 1'b1;
        bus.demod_data  = 8'h55;
        tick();
        bus.demod_valid = 1'b0;
        for (int i = 0; i < 1022; i++) begin
            tick();
            if (bus.underrun !== 1'b0 || bus.src_sel !== 2'd1) seen = 1'b1;
        end
        bus.demod_valid = 1'b1;
        bus.demod_data  = 8'h66;
        tick();
        checks++;
        if (seen || bus.src_sel !== 2'd1 || bus.da_data !== 8'h66) begin
            errors++;
            $display("FAIL hold_1022 got early=%b sel=%0d da=%h exp 0 1 66",
                     seen, bus.src_sel, bus.da_data);
        end
        bus.demod_valid = 1'b0;
    endtask

    task automatic test_underrun();
        bit seen = 1'b0;
        for (int i = 0; i < 1022; i++) begin
            tick();
            if (bus.underrun !== 1'b0 || bus.src_sel !== 2'd1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL underrun_early got 1 exp 0");
        end
        tick();
        checks++;
        if (bus.underrun !== 1'b1 || bus.src_sel !== 2'd0) begin
            errors++;
            $display("FAIL underrun_pulse got ur=%b sel=%0d exp 1 0",
                     bus.underrun, bus.src_sel);
        end
        tick();
        checks++;
        if (bus.underrun !== 1'b0 || bus.da_data !== 8'h80 ||
            bus.src_sel !== 2'd0) begin
            errors++;
            $display("FAIL underrun_after got ur=%b da=%h sel=%0d exp 0 80 0",
                     bus.underrun, bus.da_data, bus.src_sel);
        end
    endtask

    task automatic test_tone();
        logic [7:0] ea;
        logic [7:0] ed;
        logic [7:0] last;
        int         n255;
        bit         found;
        tick();
        bus.tone_en     = 1'b1;
        bus.demod_valid = 1'b1;
        bus.demod_data  = 8'h99;
        for (int i = 0; i < 40; i++) begin
            tick();
            bus.demod_valid = 1'b0;
            ea = 8'(i / 5);
            ed = (i < 2) ? 8'h80 : rom_f(8'((i - 2) / 5));
            checks++;
            if (bus.src_sel !== 2'd2 || bus.rom_addr !== ea ||
                bus.da_data !== ed) begin
                errors++;
                $display("FAIL tone_%0d got sel=%0d addr=%h da=%h exp 2 %h %h",
                         i, bus.src_sel, bus.rom_addr, bus.da_data, ea, ed);
            end
        end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (bus.rom_addr == 8'd10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL tone_addr10 got timeout exp addr 0a");
        end
        bus.tone_en = 1'b0;
        last  = 8'd0;
        n255  = 0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (bus.src_sel != 2'd2) begin
                found = 1'b1;
            end else begin
                last = bus.rom_addr;
                if (bus.rom_addr == 8'hFF) n255++;
            end
        end
        checks++;
        if (!found || last !== 8'hFF || n255 != 5) begin
            errors++;
            $display("FAIL tone_period got exit=%b last=%h n255=%0d exp 1 ff 5",
                     found, last, n255);
        end
        checks++;
        if (bus.src_sel !== 2'd0 || bus.rom_addr !== 8'd0 ||
            bus.da_data !== 8'hA5) begin
            errors++;
            $display("FAIL tone_exit got sel=%0d addr=%h da=%h exp 0 00 a5",
                     bus.src_sel, bus.rom_addr, bus.da_data);
        end
        tick();
        checks++;
        if (bus.da_data !== 8'h80) begin
            errors++;
            $display("FAIL tone_idle_code got %h exp 80", bus.da_data);
        end
    endtask

    task automatic test_async_reset();
        bus.tone_en = 1'b1;
        repeat (13) tick();
        checks++;
        if (bus.src_sel !== 2'd2 || bus.rom_addr !== 8'd2) begin
            errors++;
            $display("FAIL pre_reset got sel=%0d addr=%h exp 2 02",
                     bus.src_sel, bus.rom_addr);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.src_sel !== 2'd0 || bus.da_data !== 8'h80 ||
            bus.rom_addr !== 8'd0 || bus.underrun !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got sel=%0d da=%h addr=%h ur=%b exp 0 80 00 0",
                     bus.src_sel, bus.da_data, bus.rom_addr, bus.underrun);
        end
        bus.tone_en = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.src_sel !== 2'd0 || bus.rom_addr !== 8'd0) begin
            errors++;
            $display("FAIL reset_release got sel=%0d addr=%h exp 0 00",
                     bus.src_sel, bus.rom_addr);
        end
    endtask

    task automatic test_fast_tone();
        bit found;
        fbus.tone_en = 1'b1;
        tick();
        checks++;
        if (fbus.src_sel !== 2'd2 || fbus.rom_addr !== 8'd0) begin
            errors++;
            $display("FAIL fast_entry got sel=%0d addr=%h exp 2 00",
                     fbus.src_sel, fbus.rom_addr);
        end
        for (int i = 1; i < 300; i++) begin
            tick();
            checks++;
            if (fbus.rom_addr !== 8'(i)) begin
                errors++;
                $display("FAIL fast_step_%0d got %h exp %h",
                         i, fbus.rom_addr, 8'(i));
            end
        end
        fbus.tone_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (fbus.src_sel != 2'd2) found = 1'b1;
        end
        checks++;
        if (!found || fbus.src_sel !== 2'd0 || fbus.rom_addr !== 8'd0) begin
            errors++;
            $display("FAIL fast_exit got exit=%b sel=%0d addr=%h exp 1 0 00",
                     found, fbus.src_sel, fbus.rom_addr);
        end
    endtask

    initial begin
        bus.demod_data   = 8'd0;
        bus.demod_valid  = 1'b0;
        bus.tone_en      = 1'b0;
        fbus.demod_data  = 8'd0;
        fbus.demod_valid = 1'b0;
        fbus.tone_en     = 1'b0;
        test_reset();
        test_demod();
        test_no_underrun();
        test_underrun();
        test_tone();
        test_async_reset();
        test_fast_tone();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
